// File: rtl/aibnd_clkgate_ctrl.sv
// aibnd_clkgate_ctrl: clock-enable sequencer for the aibnd_nand2 clock gate.
// A request (req or force_on) walks OFF -> WAKE -> ON. Dropping it walks
// ON -> DRAIN -> OFF. The gate enable is retimed on the falling edge of clk,
// so it only moves while clk is low and the gated clock cannot glitch.
module aibnd_clkgate_ctrl #(
   parameter int unsigned WAKE_CYC  = 4,
   parameter int unsigned DRAIN_CYC = 2,
   parameter int unsigned CW        = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req,
   input  logic       force_on,
   input  logic       vccl_aibnd,
   input  logic       vssl_aibnd,
   output logic       en,
   output logic       ack,
   output logic       busy,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      st_off   = 2'd0,
      st_wake  = 2'd1,
      st_on    = 2'd2,
      st_drain = 2'd3
   } state_t;

   // Terminal counts of the shared settle/drain counter.
   localparam logic [CW-1:0] wake_last  = CW'(WAKE_CYC - 1);
   localparam logic [CW-1:0] drain_last = CW'(DRAIN_CYC - 1);

   state_t        cur;
   state_t        nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic          r;
   logic          en_pre;
   logic          ack_nxt;
   logic          busy_nxt;
   logic          unused_pins;

   // Supply pins carry no logic; fold them into a sink so they stay connected.
   assign unused_pins = vccl_aibnd ^ vssl_aibnd;

   // Effective request: force_on behaves as a permanent request.
   assign r = req | force_on;

   // Next-state and counter logic.
   always_comb begin
      nxt     = cur;
      cnt_nxt = cnt;
      case (cur)
         st_off: begin
            if (r) begin
               nxt     = st_wake;
               cnt_nxt = '0;
            end
         end
         st_wake: begin
            if (!r) begin
               nxt     = st_off;
               cnt_nxt = '0;
            end else if (cnt == wake_last) begin
               nxt = st_on;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         st_on: begin
            if (!r) begin
               nxt     = st_drain;
               cnt_nxt = '0;
            end
         end
         st_drain: begin
            if (r) begin
               nxt = st_on;
            end else if (cnt == drain_last) begin
               nxt     = st_off;
               cnt_nxt = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            nxt     = st_off;
            cnt_nxt = '0;
         end
      endcase
   end

   // ack/busy are registered from the next state so they track the state
   // register exactly, with no extra cycle of delay.
   always_comb begin
      ack_nxt  = (nxt == st_on);
      busy_nxt = (nxt != st_off);
   end

   // Rising-edge state, counter and status registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur  <= st_off;
         cnt  <= '0;
         ack  <= 1'b0;
         busy <= 1'b0;
      end else begin
         cur  <= nxt;
         cnt  <= cnt_nxt;
         ack  <= ack_nxt;
         busy <= busy_nxt;
      end
   end

   // The gate stays enabled through ON and the whole drain window.
   assign en_pre = (cur == st_on) || (cur == st_drain);

   // Falling-edge retime of the enable so it changes only while clk is low.
   always_ff @(negedge clk) begin
      if (rst) begin
         en <= 1'b0;
      end else begin
         en <= en_pre;
      end
   end

   assign state = cur;

endmodule

// File: tb/tb_aibnd_clkgate_ctrl.sv
// Bench for aibnd_clkgate_ctrl: directed scenarios plus bursty random requests,
// checked against a run-length model of the request history. Two instances:
// defaults (4/2) and the fastest setting (1/1) for the glitch checks.
module tb_aibnd_clkgate_ctrl;

   localparam int HALF = 5;

   logic       clk = 1'b0;
   logic       rst, req, force_on;
   logic       vccl = 1'b1;
   logic       vssl = 1'b0;
   logic       en0, ack0, busy0, en1, ack1, busy1;
   logic [1:0] st0, st1;
   logic       clkout1;
   time        t_rise = 0;

   int total = 0;
   int bad   = 0;

   // Reference model: run lengths of r high/low plus a "gate running" flag.
   int mw[2] = '{4, 1};
   int md[2] = '{2, 1};
   int run_hi[2];
   int run_lo[2];
   bit lit[2];
   int mst[2];

   logic [1:0] obs_st[2];
   logic       obs_en[2], obs_ack[2], obs_busy[2];
   logic       exp_en[2];

   aibnd_clkgate_ctrl #(.WAKE_CYC(4), .DRAIN_CYC(2), .CW(4)) u0 (
      .clk(clk), .rst(rst), .req(req), .force_on(force_on),
      .vccl_aibnd(vccl), .vssl_aibnd(vssl),
      .en(en0), .ack(ack0), .busy(busy0), .state(st0));

   aibnd_clkgate_ctrl #(.WAKE_CYC(1), .DRAIN_CYC(1), .CW(4)) u1 (
      .clk(clk), .rst(rst), .req(req), .force_on(force_on),
      .vccl_aibnd(vccl), .vssl_aibnd(vssl),
      .en(en1), .ack(ack1), .busy(busy1), .state(st1));

   always #HALF clk = ~clk;

   assign clkout1 = clk & en1;

   // en must only move while clk is low.
   always @(en0 or en1) begin
      total++;
      if (clk !== 1'b0) begin
         bad++;
         $display("FAIL en_edge_clk_high t=%0t clk=%b want=0", $time, clk);
      end
   end

   // Gated clock high pulses must be at least half a period.
   always @(posedge clkout1) t_rise = $time;
   always @(negedge clkout1) begin
      total++;
      if ($time - t_rise < HALF) begin
         bad++;
         $display("FAIL clkout_pulse t=%0t width=%0t want>=%0d", $time, $time - t_rise, HALF);
      end
   end

   function automatic void model_step(input int i, input bit r, input bit rs);
      if (rs) begin
         run_hi[i] = 0; run_lo[i] = 0; lit[i] = 0; mst[i] = 0;
         return;
      end
      if (r) begin run_hi[i]++; run_lo[i] = 0; end
      else   begin run_lo[i]++; run_hi[i] = 0; end
      if (!lit[i]) begin
         if (run_hi[i] > mw[i]) lit[i] = 1;
         mst[i] = lit[i] ? 2 : (run_hi[i] > 0 ? 1 : 0);
      end else if (r) begin
         mst[i] = 2;
      end else if (run_lo[i] > md[i]) begin
         lit[i] = 0; mst[i] = 0;
      end else begin
         mst[i] = 3;
      end
   endfunction

   // One clock: drive at posedge+1, sample en after the falling edge and
   // state/ack/busy after the rising edge that samples the inputs.
   task automatic tick(input logic rq, input logic fo, input logic rs);
      req = rq; force_on = fo; rst = rs;
      @(negedge clk); #1;
      obs_en[0] = en0; obs_en[1] = en1;
      for (int i = 0; i < 2; i++) exp_en[i] = rs ? 1'b0 : lit[i];
      @(posedge clk);
      for (int i = 0; i < 2; i++) model_step(i, rq | fo, rs);
      #1;
      obs_st[0] = st0; obs_ack[0] = ack0; obs_busy[0] = busy0;
      obs_st[1] = st1; obs_ack[1] = ack1; obs_busy[1] = busy1;
   endtask

   task automatic test_reset();
      for (int k = 0; k < 3; k++) begin
         tick(1'b0, 1'b0, 1'b1);
         total++; if (obs_en[0] !== 1'b0) begin bad++; $display("FAIL reset_en k=%0d got=%b want=0", k, obs_en[0]); end
         total++; if (obs_ack[0] !== 1'b0) begin bad++; $display("FAIL reset_ack k=%0d got=%b want=0", k, obs_ack[0]); end
         total++; if (obs_busy[0] !== 1'b0) begin bad++; $display("FAIL reset_busy k=%0d got=%b want=0", k, obs_busy[0]); end
         total++; if (obs_st[0] !== 2'd0) begin bad++; $display("FAIL reset_state k=%0d got=%0d want=0", k, obs_st[0]); end
      end
   endtask

   task automatic test_basic_release();
      for (int k = 0; k < 14; k++) begin
         tick(k < 10, 1'b0, 1'b0);
         total++; if (obs_st[0] !== 2'(mst[0])) begin bad++; $display("FAIL basic_state k=%0d got=%0d want=%0d", k, obs_st[0], mst[0]); end
         total++; if (obs_en[0] !== exp_en[0]) begin bad++; $display("FAIL basic_en k=%0d got=%b want=%b", k, obs_en[0], exp_en[0]); end
         if (k == 0) begin
            total++; if (obs_st[0] !== 2'd1 || obs_busy[0] !== 1'b1) begin bad++; $display("FAIL basic_wake k=0 state=%0d busy=%b want=1/1", obs_st[0], obs_busy[0]); end
         end
         if (k == 4) begin
            total++; if (obs_ack[0] !== 1'b1 || obs_st[0] !== 2'd2 || obs_en[0] !== 1'b0) begin bad++; $display("FAIL basic_on k=4 ack=%b state=%0d en=%b want=1/2/0", obs_ack[0], obs_st[0], obs_en[0]); end
         end
         if (k == 5) begin
            total++; if (obs_en[0] !== 1'b1) begin bad++; $display("FAIL basic_en_rise k=5 got=%b want=1", obs_en[0]); end
         end
         if (k == 10) begin
            total++; if (obs_st[0] !== 2'd3 || obs_ack[0] !== 1'b0) begin bad++; $display("FAIL release_drain k=10 state=%0d ack=%b want=3/0", obs_st[0], obs_ack[0]); end
         end
         if (k == 12) begin
            total++; if (obs_st[0] !== 2'd0 || obs_busy[0] !== 1'b0 || obs_en[0] !== 1'b1) begin bad++; $display("FAIL release_off k=12 state=%0d busy=%b en=%b want=0/0/1", obs_st[0], obs_busy[0], obs_en[0]); end
         end
         if (k == 13) begin
            total++; if (obs_en[0] !== 1'b0) begin bad++; $display("FAIL release_en_fall k=13 got=%b want=0", obs_en[0]); end
         end
      end
   endtask

   task automatic test_wake_abort();
      for (int k = 0; k < 6; k++) begin
         tick(k < 2, 1'b0, 1'b0);
         total++; if (obs_en[0] !== 1'b0 || obs_ack[0] !== 1'b0) begin bad++; $display("FAIL abort_quiet k=%0d en=%b ack=%b want=0/0", k, obs_en[0], obs_ack[0]); end
         total++; if (obs_st[0] !== 2'(mst[0])) begin bad++; $display("FAIL abort_state k=%0d got=%0d want=%0d", k, obs_st[0], mst[0]); end
         if (k == 2) begin
            total++; if (obs_st[0] !== 2'd0) begin bad++; $display("FAIL abort_off k=2 got=%0d want=0", obs_st[0]); end
         end
      end
   endtask

   task automatic test_drain_rerequest();
      int ack_lows = 0;
      for (int k = 0; k < 14; k++) begin
         tick((k < 10) && (k != 6), 1'b0, 1'b0);
         total++; if (obs_st[0] !== 2'(mst[0])) begin bad++; $display("FAIL rereq_state k=%0d got=%0d want=%0d", k, obs_st[0], mst[0]); end
         if (k >= 5 && k <= 12) begin
            total++; if (obs_en[0] !== 1'b1) begin bad++; $display("FAIL rereq_en_gap k=%0d got=%b want=1", k, obs_en[0]); end
         end
         if (k >= 5 && k <= 9 && obs_ack[0] === 1'b0) ack_lows++;
         if (k == 6) begin
            total++; if (obs_st[0] !== 2'd3 || obs_ack[0] !== 1'b0) begin bad++; $display("FAIL rereq_drain k=6 state=%0d ack=%b want=3/0", obs_st[0], obs_ack[0]); end
         end
         if (k == 7) begin
            total++; if (obs_st[0] !== 2'd2 || obs_ack[0] !== 1'b1) begin bad++; $display("FAIL rereq_on k=7 state=%0d ack=%b want=2/1", obs_st[0], obs_ack[0]); end
         end
      end
      total++; if (ack_lows != 1) begin bad++; $display("FAIL rereq_ack_low_cycles got=%0d want=1", ack_lows); end
   endtask

   task automatic test_force_and_reset();
      for (int k = 0; k < 12; k++) begin
         tick(1'($urandom_range(0, 1)), 1'b1, 1'b0);
         if (k >= 4) begin
            total++; if (obs_st[0] !== 2'd2 || obs_ack[0] !== 1'b1) begin bad++; $display("FAIL force_on k=%0d state=%0d ack=%b want=2/1", k, obs_st[0], obs_ack[0]); end
         end
         if (k >= 5) begin
            total++; if (obs_en[0] !== 1'b1) begin bad++; $display("FAIL force_en k=%0d got=%b want=1", k, obs_en[0]); end
         end
      end
      tick(1'b1, 1'b1, 1'b1);
      total++; if (obs_en[0] !== 1'b0) begin bad++; $display("FAIL midrst_en got=%b want=0", obs_en[0]); end
      total++; if (obs_st[0] !== 2'd0 || obs_ack[0] !== 1'b0 || obs_busy[0] !== 1'b0) begin bad++; $display("FAIL midrst_state state=%0d ack=%b busy=%b want=0/0/0", obs_st[0], obs_ack[0], obs_busy[0]); end
      for (int k = 0; k < 2; k++) begin
         tick(1'b0, 1'b0, 1'b0);
         total++; if (obs_en[0] !== 1'b0 || obs_st[0] !== 2'd0) begin bad++; $display("FAIL postrst_idle k=%0d en=%b state=%0d want=0/0", k, obs_en[0], obs_st[0]); end
      end
   endtask

   task automatic test_glitch_random();
      logic r_cur = 1'b0;
      for (int k = 0; k < 800; k++) begin
         if ($urandom_range(0, 3) == 0) r_cur = ~r_cur;
         tick(r_cur, 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 59) == 0));
         for (int i = 0; i < 2; i++) begin
            total++; if (obs_st[i] !== 2'(mst[i])) begin bad++; $display("FAIL rand_state dut=%0d k=%0d got=%0d want=%0d", i, k, obs_st[i], mst[i]); end
            total++; if (obs_ack[i] !== (mst[i] == 2)) begin bad++; $display("FAIL rand_ack dut=%0d k=%0d got=%b want=%b", i, k, obs_ack[i], mst[i] == 2); end
            total++; if (obs_busy[i] !== (mst[i] != 0)) begin bad++; $display("FAIL rand_busy dut=%0d k=%0d got=%b want=%b", i, k, obs_busy[i], mst[i] != 0); end
            total++; if (obs_en[i] !== exp_en[i]) begin bad++; $display("FAIL rand_en dut=%0d k=%0d got=%b want=%b", i, k, obs_en[i], exp_en[i]); end
         end
      end
   endtask

   initial begin
      rst = 1'b1; req = 1'b0; force_on = 1'b0;
      test_reset();
      test_basic_release();
      test_wake_abort();
      test_drain_rerequest();
      test_force_and_reset();
      test_glitch_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/aibnd_clkgate_ctrl.md
# aibnd_clkgate_ctrl

Clock-enable sequencer that drives the `en` input of the downstream `aibnd_nand2` clock gate. A clock request is turned into an enable that asserts only after a programmable wake-up settle and deasserts only after a programmable drain period. The enable is retimed on the falling edge of `clk` so it changes only while `clk` is low, which keeps the gated clock glitch-free. An acknowledge back to the requester confirms that the gated clock is running.

## Interface
Parameters:
- `WAKE_CYC`, default 4: cycles spent in WAKE before the enable asserts. Legal range 1..2^CW-1.
- `DRAIN_CYC`, default 2: cycles the enable is held after the request drops. Legal range 1..2^CW-1.
- `CW`, default 4: width of the shared settle/drain counter.

Ports:
- `clk` input 1: the only clock. It is the same clock that is gated downstream.
- `rst` input 1: reset, synchronous and active-high.
- `req` input 1: clock request, synchronous to `clk`.
- `force_on` input 1: test override that behaves as a permanent request.
- `vccl_aibnd` input 1: supply pin with no logical function.
- `vssl_aibnd` input 1: ground pin with no logical function.
- `en` output 1: gate enable to `aibnd_nand2.en`. It comes from a falling-edge flop.
- `ack` output 1: high only in state ON.
- `busy` output 1: high whenever the state is not OFF.
- `state` output 2: current state, encoded OFF=0, WAKE=1, ON=2, DRAIN=3.

## Operation
- Define `r` = `req` OR `force_on`, sampled on the rising edge.
- The state register, counter, `ack` and `busy` are rising-edge flops. `en` is a falling-edge flop.
- Transitions in OFF:
  - If `r`=1, go to WAKE and set cnt to 0.
  - Otherwise stay in OFF.
- Transitions in WAKE:
  - If `r`=0, go to OFF (abort); `en` never asserts.
  - Else if cnt=WAKE_CYC-1, go to ON.
  - Otherwise increment cnt.
- Transitions in ON:
  - If `r`=0, go to DRAIN and set cnt to 0.
  - Otherwise stay in ON.
- Transitions in DRAIN:
  - If `r`=1, go back to ON (re-request); `en` stays high with no gap.
  - Else if cnt=DRAIN_CYC-1, go to OFF.
  - Otherwise increment cnt.
- `en_pre` = (state==ON) OR (state==DRAIN). `en` is `en_pre` sampled on the falling edge of `clk`.
- `ack` = (state==ON) and `busy` = (state!=OFF), both decoded from the registered state with no extra delay.
- The counter never exceeds max(WAKE_CYC, DRAIN_CYC)-1 and never wraps.
- `force_on`=1 holds the block in ON regardless of `req`. It also suppresses any drain.
- Reset values: state OFF, cnt 0, `ack` 0, `busy` 0, `state` 0, `en` 0.
- `rst` overrides every transition.
- Reset mid-operation:
  - The state is OFF after the first rising edge with `rst`=1.
  - `en` clears at the first falling edge with `rst`=1, with no drain.
  - `ack` and `busy` are 0 after that rising edge.

## Timing
- Edges are numbered by the rising edge at which `r` is first sampled high (edge 0); the same numbering is used for `r` low.
- Assertion, from `r` high sampled at edge 0:
  - state WAKE after edge 0.
  - state ON and `ack`=1 after edge WAKE_CYC.
  - `en`=1 at the falling edge half a cycle after edge WAKE_CYC.
- Deassertion, from `r` low sampled at edge m in ON:
  - `ack`=0 and state DRAIN after edge m.
  - state OFF after edge m+DRAIN_CYC.
  - `en`=0 at the falling edge that follows.
- `en` changes only on falling edges, so `clk` is low at every `en` transition.
- Minimum `en` high time is DRAIN_CYC+1 cycles, for a one-cycle request that reaches ON.
- When `r` goes low and high in consecutive DRAIN cycles, the state alternates ON/DRAIN and `en` stays high continuously.

## Test plan
- Reset and basic sequence, defaults (WAKE_CYC=4, DRAIN_CYC=2):
  - Hold `rst`=1 for 3 cycles, then raise `req` at edge 0.
  - Required: `en`=0 and `ack`=0 during reset; `ack`=1 after edge 4; `en`=1 at the falling edge after edge 4; `busy`=1 from edge 0.
- Release:
  - Drop `req` at edge 10.
  - Required: state DRAIN after edge 10, `ack`=0; state OFF after edge 12; `en`=0 at the falling edge after edge 12; `busy`=0.
- Wake abort:
  - Raise `req` at edge 0 and drop it at edge 2.
  - Required: state OFF after edge 2; `en` and `ack` never assert.
- Drain re-request:
  - From ON, drop `req` at edge m and re-raise it at edge m+1.
  - Required: state ON after edge m+1; `en` stays 1 with no low pulse; `ack` low for exactly one cycle.
- Force and reset mid-operation:
  - With `force_on`=1 and `req`=0, the block must reach ON after 4 cycles and stay there.
  - Assert `rst` while in ON. Required: `en`=0 at the next falling edge; state=0 and `ack`=0 after the next rising edge.
- Glitch check with WAKE_CYC=1, DRAIN_CYC=1:
  - Toggle `req` randomly and monitor `en` and the downstream `clkout`.
  - Required: no `en` edge while `clk`=1, and no `clkout` pulse shorter than half a period.
